// File: rtl/tick_gen.sv
// Timebase for the traffic-light controller: divides clk into a one-cycle tick
// strobe at a normal or fast rate, or steps one tick per debounced button press while paused.
module tick_gen #(
  parameter int unsigned DIV       = 100_000_000,
  parameter int unsigned FAST_DIV  = 1_000_000,
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic fast,
  input  logic step_btn,
  output logic tick,
  output logic paused,
  output logic btn_db
);
  localparam int CW  = $clog2(DIV);
  localparam int DBW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0]  DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0]  FAST_M1 = CW'(FAST_DIV - 1);
  localparam logic [DBW-1:0] DB_M1   = DBW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} db_state_t;

  logic [CW-1:0]  cnt;
  logic           at_end;
  logic [1:0]     sync;
  logic           s;
  db_state_t      state_q, state_d;
  logic [DBW-1:0] db_cnt, db_cnt_d;
  logic           step_pulse;

  // >= rather than == so a DIV->FAST_DIV switch past the fast terminal count wraps on the next edge
  assign at_end = cnt >= (fast ? FAST_M1 : DIV_M1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               cnt <= '0;
    else if (!run || at_end)  cnt <= '0;
    else                      cnt <= cnt + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= '0;
    else        sync <= {sync[0], step_btn};
  end
  assign s = sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      db_cnt  <= '0;
    end else begin
      state_q <= state_d;
      db_cnt  <= db_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    db_cnt_d = db_cnt;
    case (state_q)
      IDLE: if (s) begin
        state_d  = PRESS_WAIT;
        db_cnt_d = '0;
      end
      PRESS_WAIT: begin
        if (!s)                  state_d  = IDLE;
        else if (db_cnt == DB_M1) state_d = PRESSED;
        else                     db_cnt_d = db_cnt + DBW'(1);
      end
      PRESSED: if (!s) begin
        state_d  = RELEASE_WAIT;
        db_cnt_d = '0;
      end
      RELEASE_WAIT: begin
        if (s)                   state_d  = PRESSED;
        else if (db_cnt == DB_M1) state_d = IDLE;
        else                     db_cnt_d = db_cnt + DBW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Press is accepted on the edge that leaves PRESS_WAIT for PRESSED
  always_comb begin
    step_pulse = (state_q == PRESS_WAIT) && s && (db_cnt == DB_M1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick   <= 1'b0;
      paused <= 1'b1;
      btn_db <= 1'b0;
    end else begin
      tick   <= (run & at_end) | (step_pulse & ~run);
      paused <= ~run;
      btn_db <= (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    end
  end
endmodule

// File: tb/tb_tick_gen.sv
// Scoreboard bench for tick_gen: three instances with different divisors, expected
// tick cycles queued by the stimulus and consumed by a negedge monitor.
module tb_tick_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic run_a = 1'b0, fast_a = 1'b0, btn_a = 1'b0;
  logic run_b = 1'b0, fast_b = 1'b0, btn_b = 1'b0;
  logic run_c = 1'b0, fast_c = 1'b0, btn_c = 1'b0;
  logic tick_a, paused_a, btn_db_a;
  logic tick_b, paused_b, btn_db_b;
  logic tick_c, paused_c, btn_db_c;

  tick_gen #(.DIV(5), .FAST_DIV(2), .DB_CYCLES(4)) u_a (
    .clk(clk), .rst_n(rst_n), .run(run_a), .fast(fast_a), .step_btn(btn_a),
    .tick(tick_a), .paused(paused_a), .btn_db(btn_db_a));
  tick_gen #(.DIV(8), .FAST_DIV(3), .DB_CYCLES(4)) u_b (
    .clk(clk), .rst_n(rst_n), .run(run_b), .fast(fast_b), .step_btn(btn_b),
    .tick(tick_b), .paused(paused_b), .btn_db(btn_db_b));
  tick_gen #(.DIV(10), .FAST_DIV(3), .DB_CYCLES(4)) u_c (
    .clk(clk), .rst_n(rst_n), .run(run_c), .fast(fast_c), .step_btn(btn_c),
    .tick(tick_c), .paused(paused_c), .btn_db(btn_db_c));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int id; int cyc;} exp_t;
  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;
  int base;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic expect_tick(input int id, input int c);
    exp_t e;
    e.id = id;
    e.cyc = c;
    q.push_back(e);
  endtask

  // Monitor: every observed tick must match the oldest queued expectation
  always @(negedge clk) begin
    logic [2:0] tk;
    exp_t e;
    tk = {tick_c, tick_b, tick_a};
    for (int i = 0; i < 3; i++) begin
      if (tk[i]) begin
        if (q.size() == 0) begin
          chk($sformatf("unexpected_tick_dut%0d", i), 1, 0);
        end else begin
          e = q.pop_front();
          chk($sformatf("tick_dut%0d", i), i, e.id);
          chk($sformatf("tick_cycle_dut%0d", i), cyc, e.cyc);
        end
      end
    end
  end

  task automatic wait_to(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_tick", {tick_a, tick_b, tick_c}, 0);
    chk("rst_paused", {paused_a, paused_b, paused_c}, 3'b111);
    chk("rst_btn_db", {btn_db_a, btn_db_b, btn_db_c}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    base = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Normal rate, DIV=5: ticks at edges 5,10,15; stop, then restart from zero
    run_a = 1'b1;
    do_reset();
    expect_tick(0, base + 5);
    expect_tick(0, base + 10);
    expect_tick(0, base + 15);
    wait_to(base + 16);
    chk("paused_running", paused_a, 0);
    run_a = 1'b0;
    wait_to(base + 17);
    chk("paused_after_stop", paused_a, 1);
    wait_to(base + 20);
    run_a = 1'b1;
    expect_tick(0, base + 25);
    wait_to(base + 26);
    run_a = 1'b0;
    wait_to(base + 35);

    // Switch DIV=8 -> FAST_DIV=3 while cnt=6: tick on next edge, then every 3
    run_b = 1'b1;
    do_reset();
    expect_tick(1, base + 7);
    expect_tick(1, base + 10);
    expect_tick(1, base + 13);
    expect_tick(1, base + 16);
    wait_to(base + 6);
    fast_b = 1'b1;
    wait_to(base + 17);
    run_b = 1'b0;
    fast_b = 1'b0;
    wait_to(base + 25);

    // Paused, DB_CYCLES=4: held press gives one tick at edge 7
    do_reset();
    btn_c = 1'b1;
    expect_tick(2, base + 7);
    wait_to(base + 6);
    chk("btn_db_before_accept", btn_db_c, 0);
    wait_to(base + 7);
    chk("btn_db_accepted", btn_db_c, 1);
    wait_to(base + 20);
    chk("btn_db_held", btn_db_c, 1);
    btn_c = 1'b0;
    wait_to(base + 26);
    chk("btn_db_release_wait", btn_db_c, 1);
    wait_to(base + 27);
    chk("btn_db_released", btn_db_c, 0);
    wait_to(base + 32);

    // Bounce 2 high / 2 low / 2 high: no tick, btn_db stays low
    do_reset();
    for (int i = 0; i < 16; i++) begin
      if (i == 0 || i == 4) btn_c = 1'b1;
      if (i == 2 || i == 6) btn_c = 1'b0;
      chk("btn_db_bounce", btn_db_c, 0);
      @(negedge clk);
    end

    // Running DIV=10 with a clean press: periodic ticks only, none after stop
    run_c = 1'b1;
    do_reset();
    expect_tick(2, base + 10);
    expect_tick(2, base + 20);
    expect_tick(2, base + 30);
    wait_to(base + 2);
    btn_c = 1'b1;
    wait_to(base + 12);
    btn_c = 1'b0;
    wait_to(base + 31);
    run_c = 1'b0;
    wait_to(base + 45);
    chk("paused_c_stopped", paused_c, 1);

    // Reset pulse mid-count (cnt=3): immediate reset values, then restart from zero
    run_a = 1'b1;
    do_reset();
    wait_to(base + 3);
    rst_n = 1'b0;
    #1;
    chk("midrst_tick", tick_a, 0);
    chk("midrst_paused", paused_a, 1);
    @(negedge clk);
    rst_n = 1'b1;
    base = cyc;
    expect_tick(0, base + 5);
    wait_to(base + 6);
    run_a = 1'b0;
    wait_to(base + 12);

    chk("pending_ticks", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/tick_gen.md
# tick_gen

Timebase stage directly upstream of the traffic-light controller: divides the fast system clock into a single-cycle `tick` strobe that paces every light phase. Supports a normal rate, a fast rate for bench and demo use, and a paused mode in which a debounced push-button advances the controller one tick at a time.

## Interface
- `DIV`, default 100_000_000: clk cycles per tick at normal rate; must be ≥ 2.
- `FAST_DIV`, default 1_000_000: clk cycles per tick when `fast`=1; 2 ≤ `FAST_DIV` ≤ `DIV`.
- `DB_CYCLES`, default 1_000_000: stable cycles required to accept a button level change; must be ≥ 2.
- `clk` in 1: system clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `run` in 1: synchronous level; 1 = free-running ticks, 0 = paused.
- `fast` in 1: synchronous level; selects `FAST_DIV` instead of `DIV`.
- `step_btn` in 1: raw, asynchronous, bouncing push-button input (1 = pressed).
- `tick` out 1: one-cycle strobe, registered.
- `paused` out 1: registered copy of `~run`.
- `btn_db` out 1: debounced button level, registered.

## Operation
- Reset values, applied immediately while `rst_n`=0: `tick`=0, `paused`=1, `btn_db`=0, prescaler `cnt`=0, both synchroniser flops 0, debouncer in IDLE with `db_cnt`=0.
- Active divisor: D = `fast` ? `FAST_DIV` : `DIV`. `cnt` width = clog2(`DIV`).
- Prescaler, evaluated every edge:
  - If `run`=0: `cnt`←0.
  - Else if `cnt` ≥ D−1: `cnt`←0.
  - Else: `cnt`←`cnt`+1.
- Periodic strobe: `tick` ← `run` & (`cnt` ≥ D−1).
- The ≥ compare covers a switch from `DIV` to `FAST_DIV` while `cnt` is already past `FAST_DIV`−1. In that case the tick fires on the next edge and `cnt` wraps to 0. There is no tick loss and no long stall.
- Button path: `step_btn` passes through a 2-flop synchroniser; the output is `s`.
- Debouncer FSM (states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT):
  - IDLE: if `s`=1, go to PRESS_WAIT with `db_cnt`←0.
  - PRESS_WAIT: if `s`=0, go to IDLE. Else if `db_cnt`=`DB_CYCLES`−1, go to PRESSED and emit a one-cycle `step_pulse`. Else `db_cnt`+1.
  - PRESSED: if `s`=0, go to RELEASE_WAIT with `db_cnt`←0.
  - RELEASE_WAIT: if `s`=1, go to PRESSED (no new pulse). Else if `db_cnt`=`DB_CYCLES`−1, go to IDLE. Else `db_cnt`+1.
  - `btn_db` = 1 in PRESSED and RELEASE_WAIT.
- Step tick: `tick` is also set on any edge where `step_pulse`=1 and `run`=0. Full `tick` equation: periodic term OR step term.
- While `run`=1, `step_pulse` is discarded, never queued. Because periodic ticks only occur with `run`=1, the two sources never collide.
- `tick` is never high for two consecutive cycles.

## Timing
- Free-running: with `run`=1 from reset release, first `tick` is set by edge D. Subsequent ticks follow every D edges; the period is exactly D cycles.
- `run` 1→0: `cnt` is cleared on the same edge and any partial count is lost. `paused`=1 one edge after `run` falls.
- `run` 0→1: the counting restarts from 0 and the first tick comes D edges later.
- Step latency: `step_btn` rises stably before edge 1. `tick` is set by edge `DB_CYCLES`+3 and is high for one cycle.
- One press produces one tick, however long the button is held or bounced.
- Bounces shorter than `DB_CYCLES` cycles produce no tick, on either press or release.
- Reset assertion mid-count or mid-debounce: all state returns to reset values asynchronously. After release, behaviour is as from power-up.

## Test plan
- `DIV`=5, `run`=1, `fast`=0 from reset release → `tick` is high for one cycle at edges 5, 10, 15; low otherwise.
- `DIV`=8, `FAST_DIV`=3, `run`=1. Raise `fast` when `cnt`=6 → `tick` at the next edge and `cnt`=0. Following ticks come every 3 edges.
- `run`=0, `DB_CYCLES`=4. Hold `step_btn`=1 for 20 cycles → exactly one `tick`, set by edge 7. `btn_db`=1 from edge 7.
- `run`=0, `DB_CYCLES`=4. Pulse `step_btn` high for 2 cycles, low for 2, high for 2 → no `tick`, and `btn_db` stays 0.
- `run`=1, `DIV`=10, with a clean step press → periodic ticks only, every 10 edges. No extra tick, and none appears after `run` later falls.
- Assert `rst_n`=0 for 1 cycle mid-count (`cnt`=3, `DIV`=5) → `tick`=0 and `paused`=1 immediately. After release with `run`=1, the first tick is at edge 5.
